// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder.
// Holds the FSM state type, byte-lane count and read-latency ceiling.
package dsram_pkg;

    localparam int RD_LAT_MAX = 3;
    localparam int BYTE_LANES = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/dsram_responder_if.sv
// Data-memory request/response bundle between a requester and the SRAM.
// master drives the request side, slave returns read data and status.
interface dsram_responder_if;
    import dsram_pkg::*;

    logic                  data_sram_en;
    logic [BYTE_LANES-1:0] data_sram_wen;
    logic [31:0]           data_sram_addr;
    logic [31:0]           data_sram_wdata;
    logic [31:0]           data_sram_rdata;
    logic                  dsram_rvalid;
    logic                  dsram_addr_err;
    logic                  dsram_ready;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  dsram_rvalid,
        input  dsram_addr_err,
        input  dsram_ready
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output dsram_rvalid,
        output dsram_addr_err,
        output dsram_ready
    );

endinterface

// File: rtl/dsram_rd_pipe.sv
// Read-response delay line of LAT stages for valid, data and error.
// Data stages only load behind a valid, so the output holds its last read.
module dsram_rd_pipe
    import dsram_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_err,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_err
);

    logic [LAT-1:0] v;
    logic [LAT-1:0] e;
    logic [31:0]    d [LAT];

    // Shift valid/err every cycle; move data only alongside a valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            e <= '0;
            for (int k = 0; k < LAT; k++) begin
                d[k] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            e[0] <= in_valid & in_err;
            if (in_valid) begin
                d[0] <= in_data;
            end
            for (int k = 1; k < LAT; k++) begin
                v[k] <= v[k-1];
                e[k] <= v[k-1] & e[k-1];
                if (v[k-1]) begin
                    d[k] <= d[k-1];
                end
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_err   = e[LAT-1];
    assign out_data  = d[LAT-1];

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: byte-writable word RAM, self-clears after reset.
// Optional access counters when DSRAM_ACCESS_CNT_EN is defined.
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    dsram_responder_if.slave bus
`ifdef DSRAM_ACCESS_CNT_EN
    ,
    output logic [31:0] dsram_rd_cnt,
    output logic [31:0] dsram_wr_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              ready_q;
    logic              werr_q;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              serve;
    logic              wr_req;
    logic              rd_req;
    logic              wr_fire;
    logic [31:0]       rd_data;

    logic              p_valid;
    logic [31:0]       p_data;
    logic              p_err;

    wire unused_lo = ^bus.data_sram_addr[1:0];

    assign idx      = bus.data_sram_addr[ADDR_W+1:2];
    assign in_range = bus.data_sram_addr[31:ADDR_W+2]
                   == BASE_ADDR[31:ADDR_W+2];
    assign serve    = !reset && state == READY
                   && bus.data_sram_en;
    assign wr_req   = serve && |bus.data_sram_wen;
    assign rd_req   = serve && bus.data_sram_wen == '0;
    assign wr_fire  = wr_req && in_range;
    assign rd_data  = in_range ? mem[idx] : 32'h0;

    // Clear sequencer: sweep every word once, then serve until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            ptr     <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Storage: zero-fill while clearing, byte-lane writes when serving.
    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (bus.data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Dropped out-of-window writes flag an error on the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            werr_q <= 1'b0;
        end else begin
            werr_q <= wr_req && !in_range;
        end
    end

    dsram_rd_pipe #(
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_req),
        .in_data   (rd_data),
        .in_err    (!in_range),
        .out_valid (p_valid),
        .out_data  (p_data),
        .out_err   (p_err)
    );

    assign bus.data_sram_rdata = p_data;
    assign bus.dsram_rvalid    = p_valid;
    assign bus.dsram_addr_err  = p_err | werr_q;
    assign bus.dsram_ready     = ready_q;

`ifdef DSRAM_ACCESS_CNT_EN
    // Count accepted in-window reads and writes, wrapping at 2**32.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsram_rd_cnt <= '0;
            dsram_wr_cnt <= '0;
        end else begin
            if (rd_req && in_range) begin
                dsram_rd_cnt <= dsram_rd_cnt + 32'd1;
            end
            if (wr_fire) begin
                dsram_wr_cnt <= dsram_wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder with randomized requests.
// Reference memory is a plain word array updated per request.
module tb_dsram_responder;
    import dsram_pkg::*;

    localparam int          AW    = 4;
    localparam int          LAT   = 3;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dsram_responder_if bus();

`ifdef DSRAM_ACCESS_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    dsram_responder #(
        .ADDR_W    (AW),
        .RD_LAT    (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef DSRAM_ACCESS_CNT_EN
        ,
        .dsram_rd_cnt (rd_cnt),
        .dsram_wr_cnt (wr_cnt)
`endif
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    rd_exp_t     rq[$];
    int          wq[$];
    logic [31:0] model [DEPTH];
    int          m_rd = 0;
    int          m_wr = 0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit in_win(logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected reads on rvalid and check addr_err pulses.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        bit      exp_err;
        exp_err = 1'b0;
        if (!reset) begin
            if (bus.dsram_rvalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = rq.pop_front();
                    check("rd_latency", cyc, e.due);
                    check("rdata", bus.data_sram_rdata, e.data);
                    exp_err = e.err;
                    last_rdata = e.data;
                end
            end else begin
                check("rdata_hold", bus.data_sram_rdata, last_rdata);
                if (rq.size() > 0 && rq[0].due < cyc) begin
                    check("missing_rvalid", 32'd0, 32'd1);
                    void'(rq.pop_front());
                end
            end
            if (wq.size() > 0 && wq[0] <= cyc) begin
                exp_err = 1'b1;
                void'(wq.pop_front());
            end
            if (bus.dsram_addr_err || exp_err) begin
                check("addr_err", 32'(bus.dsram_addr_err),
                      32'(exp_err));
            end
        end
    end

    task automatic issue(bit en, logic [3:0] wen,
                         logic [31:0] addr, logic [31:0] wd);
        int e;
        int w;
        @(negedge clk);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wd;
        e = cyc + 1;
        w = widx(addr);
        if (en) begin
            if (wen != 4'h0) begin
                if (in_win(addr)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wen[i]) model[w][8*i +: 8] = wd[8*i +: 8];
                    end
                    m_wr++;
                end else begin
                    wq.push_back(e);
                end
            end else begin
                if (in_win(addr)) begin
                    rq.push_back('{e + LAT - 1, model[w], 1'b0});
                    m_rd++;
                end else begin
                    rq.push_back('{e + LAT - 1, 32'h0, 1'b1});
                end
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            issue(1'b0, 4'($urandom), $urandom, $urandom);
        end
    endtask

    task automatic check_counts();
`ifdef DSRAM_ACCESS_CNT_EN
        check("rd_cnt", rd_cnt, 32'(m_rd));
        check("wr_cnt", wr_cnt, 32'(m_wr));
`endif
    endtask

    // Pulse reset, then count cycles to ready while firing ignored requests.
    task automatic do_reset(int abort_at);
        int n;
        idle(LAT + 2);
        check("queues_drained", 32'(rq.size() + wq.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.data_sram_en = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.dsram_ready), 32'd0);
        check("rst_rvalid", 32'(bus.dsram_rvalid), 32'd0);
        check("rst_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_addr_err", 32'(bus.dsram_addr_err), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        m_rd = 0;
        m_wr = 0;
        check_counts();
        rq.delete();
        wq.delete();
        last_rdata = 32'h0;
        reset = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (abort_at > 0 && n == abort_at) begin
                check("ready_mid_clear", 32'(bus.dsram_ready), 32'd0);
                bus.data_sram_en = 1'b0;
                return;
            end
            if (bus.dsram_ready) break;
            bus.data_sram_en    = 1'b1;
            bus.data_sram_wen   = 4'($urandom);
            bus.data_sram_addr  = ($urandom_range(0, 3) == 0)
                                ? $urandom
                                : BASE + 32'($urandom_range(0, 63));
            bus.data_sram_wdata = $urandom | 32'h1;
        end
        bus.data_sram_en = 1'b0;
        check("clear_cycles", 32'(n), 32'(DEPTH));
        check_counts();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 4'h0, BASE + 32'(4 * i), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  wn;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        do_reset(0);
        issue(1'b1, 4'h0, BASE + 32'h8, $urandom);

        issue(1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
        issue(1'b1, 4'b0010, BASE + 32'h10, 32'h0000_5500);
        issue(1'b1, 4'h0, BASE + 32'h10, 32'h0);

        issue(1'b1, 4'hF, BASE + 32'h0, 32'h11);
        issue(1'b1, 4'hF, BASE + 32'h4, 32'h22);
        issue(1'b1, 4'hF, BASE + 32'h8, 32'h33);
        issue(1'b1, 4'h0, BASE + 32'h0, 32'h0);
        issue(1'b1, 4'h0, BASE + 32'h4, 32'h0);
        issue(1'b1, 4'h0, BASE + 32'h8, 32'h0);

        issue(1'b1, 4'h0, 32'h2000_0000, 32'h0);
        issue(1'b1, 4'hF, 32'h2000_0000, 32'hFFFF_FFFF);
        issue(1'b1, 4'hF, 32'h1000_0040, 32'hFFFF_FFFF);
        read_all();

        for (int i = 0; i < 500; i++) begin
            a = ($urandom_range(0, 7) == 0)
              ? $urandom : BASE + 32'($urandom_range(0, 63));
            wn = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            issue($urandom_range(0, 9) != 0, wn, a, $urandom);
        end
        read_all();
        idle(LAT + 2);
        check_counts();

        issue(1'b1, 4'hF, BASE + 32'hC, 32'hAAAA_AAAA);
        issue(1'b1, 4'h0, BASE + 32'hC, 32'h0);
        do_reset(0);
        issue(1'b1, 4'h0, BASE + 32'hC, 32'h0);

        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
        end
        do_reset(7);
        do_reset(0);
        read_all();
        idle(LAT + 2);
        check("final_drain", 32'(rq.size() + wq.size()), 32'd0);
        check_counts();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
Data-SRAM responder for the pipeline's data-memory request port; the memory-side counterpart of the execute stage that drives en/wen/addr/wdata.
- Single-port word RAM with per-byte write enables and configurable read latency.
- Self-clears its contents after reset, then raises dsram_ready.
- Flags accesses outside its address window.
- Used as the memory-stage data source in simulation and FPGA bring-up.

Parameters:
ADDR_W, 10, log2 of the word count (depth = 2**ADDR_W words).
RD_LAT, 1, read latency in cycles from request to dsram_rvalid; legal values 1..3.
BASE_ADDR, 32'h0000_0000, byte base of the window; aligned to 4*2**ADDR_W.

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-high reset
data_sram_en  in  1  request valid this cycle
data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]
data_sram_addr  in  32  byte address; bits [1:0] ignored
data_sram_wdata  in  32  write data
data_sram_rdata  out  32  read data, valid when dsram_rvalid=1
dsram_rvalid  out  1  one-cycle pulse per completed read
dsram_addr_err  out  1  pulses with dsram_rvalid for an out-of-range read; one-cycle pulse for an out-of-range write
dsram_ready  out  1  high once clearing is done

Behaviour:
Reset state:
- rdata=0, rvalid=0, addr_err=0, ready=0.
- FSM enters CLEAR; clear pointer=0; read pipeline flushed.

FSM states:
- CLEAR: writes 32'h0 to word[ptr], then ptr++ each cycle. After the write of word 2**ADDR_W-1, moves to READY, so ready=1 exactly 2**ADDR_W cycles after reset deasserts.
- While in CLEAR: all requests are ignored (no write, no rvalid, no addr_err).
- READY: serves requests. Stays in READY until reset.
- Reset mid-CLEAR or in READY restarts CLEAR from ptr=0.

Decode:
- word index = addr[ADDR_W+1:2].
- in_range = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).

Write (READY, en=1, wen!=0):
- Enabled byte lanes are updated at the same clock edge; other lanes keep their value.
- Writes produce no rvalid.
- An out-of-range write is dropped and addr_err pulses the next cycle.

Read (READY, en=1, wen=0):
- Request sampled at edge N; rdata and rvalid are presented in cycle N+RD_LAT.
- Out-of-range read: returns rdata=32'h0 with rvalid=1 and addr_err=1 at the same latency.

Ordering and pipelining:
- A read issued the cycle after a write to the same word returns the new data (write-first ordering; no stale bypass).
- Back-to-back reads are accepted every cycle; the responder never stalls once ready.
- rdata holds its last value when rvalid=0.

Other rules:
- en=0 means no operation, regardless of wen.
- One port, so simultaneous read+write is impossible; en=1 with wen!=0 is always treated as a write.

Optional Feature:
DSRAM_ACCESS_CNT_EN:
- When defined, adds two outputs, dsram_rd_cnt[31:0] and dsram_wr_cnt[31:0].
- Each increments by 1 per accepted in-range read or write in READY.
- Both are cleared by reset and wrap from 32'hFFFF_FFFF to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
Package dsram_pkg holds:
- the state enum (CLEAR, READY);
- RD_LAT_MAX=3;
- the BYTE_LANES=4 constant.

One natural sub-module, dsram_rd_pipe:
- RD_LAT-deep valid/data/err delay line;
- flushed by reset.

The top level holds the storage array, FSM, decode and write logic.

Test Plan:
1. Reset with ADDR_W=4 -> ready=0 for exactly 16 cycles, then 1. Read of 0x0000_0008 returns 0 with rvalid one cycle later (RD_LAT=1).
2. Write addr 0x10, wen=4'hF, wdata 0xDEADBEEF, then wen=4'b0010 with wdata 0x0000_5500. Next cycle read 0x10 -> rdata 0xDEAD55EF.
3. RD_LAT=3, reads of 0x0,0x4,0x8 on consecutive cycles holding 0x11,0x22,0x33 -> rvalid high on cycles N+3..N+5 with data 0x11,0x22,0x33 in order.
4. BASE_ADDR=0x1000_0000, read 0x2000_0000 -> rvalid=1, addr_err=1, rdata=0. Write 0x2000_0000 -> addr_err pulse; memory unchanged, confirmed by re-reading all words.
5. Assert reset for 1 cycle midway through READY after writing 0xAAAA_AAAA to word 3 -> ready drops, re-clears, and word 3 reads back 0.
6. With DSRAM_ACCESS_CNT_EN: 5 writes, 7 reads, 2 out-of-range reads -> wr_cnt=5, rd_cnt=7. Requests issued during CLEAR leave both counters at 0.
